irq_arbiter: RTL and testbench

Memory-mapped interrupt controller that shares the CPU's single external-interrupt line among up to 16 peripheral sources, including the timer/counter `IRQ` outputs.
- Captures source rising edges into pending bits and applies a software mask.
- Grants one source at a time by fixed priority and holds the grant until software signals end-of-interrupt.
- Sits on the system bridge next to the timers; its `irq_out` feeds one CP0 HWInt bit.

---
 rtl/irq_arbiter.sv | 98 +++++++++
 tb/tb_irq_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter: memory-mapped fixed-priority interrupt controller sharing one CPU interrupt line
//   clk, reset       : system clock, synchronous active-high reset
//   src_irq[NSRC]    : level interrupt requests, rising edges latch into PEND (source 0 = highest priority)
//   Addr[31:2], WE,
//   Din, Dout        : bridge port, Addr[3:2] selects MASK / PEND (w1c) / CUR / EOI; Dout is combinational
//   irq_out, cur_id  : registered grant to CP0 and id of the granted source
//   IRQ_SYNC_EN      : when defined, src_irq passes a two-flop synchronizer before edge detection
module irq_arbiter #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic            irq_out,
  output logic [3:0]      cur_id
);
  typedef enum logic [1:0] {IDLE, ARB, SERVE} state_t;
  state_t          state_q, state_d;
  logic [NSRC-1:0] mask_q, mask_d, pend_q, pend_d, prev_q, src, rise, elig, clr, grant_bit;
  logic            irq_q, irq_d, wr_mask, wr_pend, wr_eoi;
  logic [3:0]      cur_q, cur_d, k;
  logic            unused_bits;
`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= src_irq;
      s2_q <= s1_q;
    end
  end
  assign src = s2_q;
`else
  assign src = src_irq;
`endif
  assign wr_mask     = WE && Addr[3:2] == 2'd0;
  assign wr_pend     = WE && Addr[3:2] == 2'd1;
  assign wr_eoi      = WE && Addr[3:2] == 2'd3;
  assign rise        = src & ~prev_q;
  assign elig        = pend_q & mask_q;
  assign unused_bits = ^{Addr[31:4], Din[31:NSRC]};
  always_comb begin
    k = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (elig[i]) k = 4'(i);
  end
  assign grant_bit = (state_q == ARB && |elig) ? NSRC'(1) << k : '0;
  // a new edge on the same bit re-sets it, so set wins over both w1c and grant clear
  assign clr    = (wr_pend ? Din[NSRC-1:0] : '0) | grant_bit;
  assign pend_d = (pend_q & ~clr) | rise;
  assign mask_d = wr_mask ? Din[NSRC-1:0] : mask_q;
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    cur_d   = cur_q;
    unique case (state_q)
      IDLE:    state_d = |elig ? ARB : IDLE;
      ARB: begin
        state_d = |elig ? SERVE : IDLE;
        irq_d   = |elig;
        cur_d   = |elig ? k : cur_q;
      end
      SERVE: begin
        state_d = wr_eoi ? IDLE : SERVE;
        irq_d   = !wr_eoi;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      irq_q   <= 1'b0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      prev_q  <= src;
      irq_q   <= irq_d;
      cur_q   <= cur_d;
    end
  end
  assign Dout    = Addr[3:2] == 2'd0 ? 32'(mask_q) :
                   Addr[3:2] == 2'd1 ? 32'(pend_q) :
                   Addr[3:2] == 2'd2 ? {irq_q, 27'b0, cur_q} : 32'b0;
  assign irq_out = irq_q;
  assign cur_id  = cur_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: randomized and directed stimulus checked against a cycle-level reference model
module tb_irq_arbiter;
  localparam int NSRC = 6;
  localparam int FULL = (1 << NSRC) - 1;
`ifdef IRQ_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif
  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src_irq;
  logic [31:2]     Addr;
  logic            WE;
  logic [31:0]     Din, Dout;
  logic            irq_out;
  logic [3:0]      cur_id;
  int n_cmp = 0, n_bad = 0;
  int m_mask, m_pend, m_prev, m_id, m_streak;
  bit m_serving;
  int hist[$];
  always #5 clk = ~clk;
  irq_arbiter #(.NSRC(NSRC)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .Addr(Addr), .WE(WE),
    .Din(Din), .Dout(Dout), .irq_out(irq_out), .cur_id(cur_id)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int m_read(input int a);
    case (a)
      0: return m_mask;
      1: return m_pend;
      2: return (int'(m_serving) << 31) | m_id;
      default: return 0;
    endcase
  endfunction
  // one clock: drive inputs, check combinational read, advance model, check registered outputs
  task automatic step(input bit r, input int s, input bit we, input int a, input int d);
    int eff, rise, elig, clr;
    reset   = r;
    src_irq = s[NSRC-1:0];
    Addr    = 30'($urandom);
    Addr[3:2] = a[1:0];
    WE      = we;
    Din     = d;
    #1;
    if (!r) chk("dout", Dout, m_read(a));
    if (r) begin
      m_mask = 0; m_pend = 0; m_prev = 0; m_id = 0; m_streak = 0; m_serving = 0;
      hist.delete();
    end else begin
      hist.push_back(s & FULL);
      eff = hist.size() > DLY ? hist[hist.size() - 1 - DLY] : 0;
      if (hist.size() > 3) void'(hist.pop_front());
      rise = eff & ~m_prev;
      elig = m_pend & m_mask;
      clr  = (we && a == 1) ? (d & FULL) : 0;
      // a grant needs eligibility on two consecutive idle edges; EOI only ends an active service
      if (m_serving) begin
        if (we && a == 3) begin m_serving = 0; m_streak = 0; end
      end else if (elig == 0) m_streak = 0;
      else if (m_streak == 0) m_streak = 1;
      else begin
        for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) m_id = i;
        clr |= 1 << m_id;
        m_serving = 1;
        m_streak = 0;
      end
      m_pend = (m_pend & ~clr) | rise;
      if (we && a == 0) m_mask = d & FULL;
      m_prev = eff;
    end
    @(posedge clk);
    @(negedge clk);
    chk("irq_out", irq_out, m_serving);
    if (m_serving || r) chk("cur_id", cur_id, m_id);
  endtask
  initial begin
    int s;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 1, 0, 'hFFFF_FF3F);
    for (int i = 0; i < 6; i++) step(0, 'h04, 0, i % 3, 0);
    step(0, 'h04, 1, 3, 0);
    step(0, 'h00, 0, 1, 0);
    step(0, 'h12, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 'h12, 0, 1 + i % 2, 0);
    step(0, 'h12, 1, 3, 0);
    for (int i = 0; i < 5; i++) step(0, 'h12, 0, 2, 0);
    step(0, 'h00, 1, 3, 0);
    step(0, 'h00, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 'h01, 0, 1, 0);
    step(0, 'h01, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 'h01, 0, 2, 0);
    step(0, 'h00, 1, 3, 0);
    step(0, 'h00, 1, 0, 0);
    step(0, 'h00, 1, 1, 'h3F);
    step(0, 'h01, 1, 1, 'h01);
    step(0, 'h01, 0, 1, 0);
    step(0, 'h00, 1, 0, 'h3F);
    for (int i = 0; i < 5; i++) step(0, 'h08, 0, 2, 0);
    step(0, 'h08, 1, 3, 0);
    for (int i = 0; i < 3; i++) step(0, 'h08, 0, 2, 0);
    step(1, 'h08, 0, 2, 0);
    step(0, 'h00, 0, 2, 0);
    step(0, 'h00, 0, 0, 0);
    s = 0;
    for (int n = 0; n < 4000; n++) begin
      bit we;
      int a, d;
      if ($urandom_range(0, 2) == 0) s ^= 1 << $urandom_range(0, NSRC - 1);
      we = $urandom_range(0, 3) == 0;
      a  = $urandom_range(0, 3);
      d  = (a == 1 && $urandom_range(0, 1) == 0) ? (1 << $urandom_range(0, NSRC - 1)) : int'($urandom);
      step($urandom_range(0, 299) == 0, s, we, a, d);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
